prt_slot_table: RTL and testbench
=================================

# prt_slot_table

Parametrised packet reference table. It stores up to NUM_SLOTS frames of up to MEM_DEPTH beats each, with a per-slot beat length, and supports one write session and one read session concurrently. It adds write abort, deferred free of slots under read, a free-slot count and optional multicast reference counting. It sits between the ingress parser, which writes frames, and the egress scheduler, which reads and invalidates them.

## Interface
- DATA_WIDTH, 32: beat width in bits.
- MEM_DEPTH, 512: maximum beats per slot.
- NUM_SLOTS, 16: number of slots, at least 2.
- REF_WIDTH, 3: refcount width; used only with PRT_MULTICAST_EN.
- SLOT_W = $clog2(NUM_SLOTS); LEN_W = $clog2(MEM_DEPTH+1) (derived).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN_start_writing_prt_entry / RDY_start_writing_prt_entry  in/out  1  open a write session.
- start_writing_prt_entry  out  SLOT_W  slot that will be allocated; valid while RDY is high.
- EN_write_prt_entry / RDY_write_prt_entry  in/out  1  write one beat.
- write_prt_entry_data  in  DATA_WIDTH  beat data.
- EN_finish_writing_prt_entry / RDY_finish_writing_prt_entry  in/out  1  commit the frame.
- EN_abort_writing_prt_entry / RDY_abort_writing_prt_entry  in/out  1  discard the frame.
- EN_invalidate_prt_entry / RDY_invalidate_prt_entry  in/out  1  release a slot.
- invalidate_prt_entry_slot  in  SLOT_W  slot to release.
- EN_start_reading_prt_entry / RDY_start_reading_prt_entry  in/out  1  open a read session.
- start_reading_prt_entry_slot  in  SLOT_W  slot to read.
- EN_read_prt_entry / RDY_read_prt_entry  in/out  1  consume the current beat.
- read_prt_entry  out  DATA_WIDTH+1  {last, data}.
- is_prt_slot_free  out  1  at least one slot is FREE and not pending-free.
- free_slot_count  out  SLOT_W+1  number of FREE slots.
- start_writing_prt_entry_refs  in  REF_WIDTH  copies to hold; exists only with PRT_MULTICAST_EN.

## Operation
- Each slot has a state: FREE, WRITING or VALID. Each slot also holds a length register and a pending_free bit.
- Allocation: start_writing_prt_entry is the lowest-index FREE slot. RDY_start_writing is high when a slot is free and no write session is open. EN moves the slot to WRITING and clears the beat pointer.
- Write: RDY_write is high while the session is open and the pointer is below MEM_DEPTH. Each EN stores the beat at the pointer and increments the pointer. Beats offered past MEM_DEPTH are impossible because RDY is low.
- Finish: RDY is high while the session is open. EN sets length to the pointer and moves the slot to VALID. A zero-beat finish is legal and gives length 0.
- Abort: EN returns the WRITING slot to FREE and closes the session.
- Read: RDY_start_reading is high when no read session is open. If the target slot is VALID with length ≥ 1, beats are streamed in order and last = 1 on beat length-1. Otherwise a single beat {1, 0} is returned.
- EN_read on the last beat closes the session.
- Invalidate: RDY is always high (outside reset).
  - VALID slot not under read: becomes FREE.
  - VALID slot under read: pending_free is set; the slot becomes FREE in the cycle its read session closes.
  - FREE or WRITING slot: no effect.
- State updates are registered. A slot freed in cycle N is allocatable from N+1.
- Same-cycle events:
  - Invalidate and start_reading on the same slot: invalidate takes effect first, so the read sees a non-VALID slot.
  - Finish and start_reading on the slot being finished: the read sees WRITING and returns {1, 0}.
  - Write and read sessions on different slots run fully concurrently.

## Timing
- Reset, synchronous and active-high: all slots FREE, no sessions, pending_free cleared, free_slot_count = NUM_SLOTS, is_prt_slot_free = 1.
- All RDY_* = 0 while RST is high, except RDY_start_writing, which follows its normal rule and is 1 from the first cycle after reset.
- read_prt_entry = 0 during reset.
- Reset mid-session discards both sessions and all contents.
- Read latency: EN_start_reading in cycle N gives RDY_read_prt_entry and beat 0 valid in cycle N+2.
- Each EN_read in cycle M presents the next beat in M+1, so sustained throughput is 1 beat per cycle.
- After the last beat is consumed, RDY_read is 0 from the next cycle.
- Write throughput is 1 beat per cycle. Finish may be asserted in the cycle after the last write.
- RAM is simple dual-port with synchronous read. The RAM address is slot*MEM_DEPTH + pointer.

## Configuration
- PRT_MULTICAST_EN defined:
  - A per-slot refcount is loaded at start_writing from start_writing_prt_entry_refs; a value of 0 is treated as 1.
  - Each invalidate of a VALID slot decrements the refcount. Free or pending_free happens only on the invalidate that sees refcount 1.
- PRT_MULTICAST_EN undefined: the port and refcount storage are absent, and a single invalidate frees the slot.

## Structure
- Shared package prt_pkg:
  - slot_state_e (FREE, WRITING, VALID).
  - A function returning SLOT_W from NUM_SLOTS.
  - The read-beat struct {last, data}.
- Sub-module prt_slot_ram: a parametrised simple dual-port synchronous RAM of NUM_SLOTS*MEM_DEPTH words of DATA_WIDTH bits.
- Control logic (slot state, allocation, sessions) lives in prt_slot_table.

## Test plan
- Basic write/read: after reset, write 5 beats 0..4 and finish → slot 0. Read slot 0 → beats 0..4 on consecutive cycles, last only on beat 4. RDY_read is low in the cycle after.
- Fill and reuse: write all 16 slots → is_prt_slot_free = 0 and free_slot_count = 0. Invalidate slot 7 → count 1 the next cycle. The next allocation is slot 7.
- Abort: start a write to slot 0, write 3 beats, abort → free_slot_count returns to 16. Reading slot 0 → a single beat {1, 0}.
- Deferred free: read a 4-beat slot 2 and invalidate slot 2 at beat 1 → slot 2 stays unallocatable until beat 3 is consumed, then becomes FREE one cycle later.
- Concurrency and overflow: write 512 beats to slot 1 while reading slot 0 → RDY_write drops after beat 512, and the read data is unaffected.
- Multicast (with PRT_MULTICAST_EN): refs = 3, then invalidate ×2 → slot still VALID. A third invalidate → FREE. With refs = 0, one invalidate frees the slot.

Source files
------------

// File: rtl/prt_pkg.sv
// prt_pkg: slot states, slot-index width helper and the read-beat layout shared by the packet reference table
package prt_pkg;
   typedef enum logic [1:0] {FREE, WRITING, VALID} slot_state_e;
   localparam int PRT_DATA_WIDTH = 32;
   typedef struct packed {
      logic                      last;
      logic [PRT_DATA_WIDTH-1:0] data;
   } prt_beat_t;
   function automatic int slot_w(input int num_slots);
      return $clog2(num_slots);
   endfunction
endpackage

// File: rtl/prt_slot_ram.sv
// prt_slot_ram: simple dual-port RAM with registered read, one word per slot beat
module prt_slot_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int WORDS      = 8192,
   localparam int AW        = $clog2(WORDS)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem_q [WORDS];
   logic [DATA_WIDTH-1:0] rdata_q;
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      rdata_q <= mem_q[raddr];
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/prt_slot_table.sv
// prt_slot_table: packet reference table with concurrent write/read sessions, abort and deferred free.
// Define PRT_MULTICAST_EN to add per-slot reference counting on invalidate.
module prt_slot_table
   import prt_pkg::*;
#(
   parameter int DATA_WIDTH = PRT_DATA_WIDTH,
   parameter int MEM_DEPTH  = 512,
   parameter int NUM_SLOTS  = 16,
   parameter int REF_WIDTH  = 3,
   localparam int SLOT_W    = slot_w(NUM_SLOTS),
   localparam int LEN_W     = $clog2(MEM_DEPTH + 1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN_start_writing_prt_entry,
   output logic                  RDY_start_writing_prt_entry,
   output logic [SLOT_W-1:0]     start_writing_prt_entry,
`ifdef PRT_MULTICAST_EN
   input  logic [REF_WIDTH-1:0]  start_writing_prt_entry_refs,
`endif
   input  logic                  EN_write_prt_entry,
   output logic                  RDY_write_prt_entry,
   input  logic [DATA_WIDTH-1:0] write_prt_entry_data,
   input  logic                  EN_finish_writing_prt_entry,
   output logic                  RDY_finish_writing_prt_entry,
   input  logic                  EN_abort_writing_prt_entry,
   output logic                  RDY_abort_writing_prt_entry,
   input  logic                  EN_invalidate_prt_entry,
   output logic                  RDY_invalidate_prt_entry,
   input  logic [SLOT_W-1:0]     invalidate_prt_entry_slot,
   input  logic                  EN_start_reading_prt_entry,
   output logic                  RDY_start_reading_prt_entry,
   input  logic [SLOT_W-1:0]     start_reading_prt_entry_slot,
   input  logic                  EN_read_prt_entry,
   output logic                  RDY_read_prt_entry,
   output logic [DATA_WIDTH:0]   read_prt_entry,
   output logic                  is_prt_slot_free,
   output logic [SLOT_W:0]       free_slot_count
);
   localparam int AW = $clog2(NUM_SLOTS * MEM_DEPTH);
   slot_state_e           state_q [NUM_SLOTS], state_d [NUM_SLOTS];
   logic [LEN_W-1:0]      len_q [NUM_SLOTS], len_d [NUM_SLOTS];
   logic [NUM_SLOTS-1:0]  pend_q, pend_d;
   logic                  wr_open_q, wr_open_d, rd_open_q, rd_open_d;
   logic                  rd_valid_q, rd_valid_d, rd_null_q, rd_null_d;
   logic [SLOT_W-1:0]     wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d, alloc;
   logic [LEN_W-1:0]      wr_ptr_q, wr_ptr_d, rd_idx_q, rd_idx_d, rd_fa;
   logic [SLOT_W:0]       free_cnt;
   logic                  any_free, do_start, do_write, do_finish, do_abort, do_inv, do_rstart, do_read;
   logic                  rd_last, rd_close, inv_valid, inv_last, ref_one, rd_ok;
   logic [AW-1:0]         wr_addr, rd_addr;
   logic [DATA_WIDTH-1:0] ram_rdata, rd_data;
   always_comb begin
      alloc = '0;
      any_free = 1'b0;
      free_cnt = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if (state_q[i] == FREE) begin
            alloc = SLOT_W'(i);
            any_free = 1'b1;
            free_cnt = free_cnt + 1'b1;
         end
   end
   assign RDY_start_writing_prt_entry  = any_free && !wr_open_q;
   assign start_writing_prt_entry      = alloc;
   assign RDY_write_prt_entry          = !RST && wr_open_q && wr_ptr_q < LEN_W'(MEM_DEPTH);
   assign RDY_finish_writing_prt_entry = !RST && wr_open_q;
   assign RDY_abort_writing_prt_entry  = !RST && wr_open_q;
   assign RDY_invalidate_prt_entry     = !RST;
   assign RDY_start_reading_prt_entry  = !RST && !rd_open_q;
   assign RDY_read_prt_entry           = !RST && rd_valid_q;
   assign is_prt_slot_free             = any_free;
   assign free_slot_count              = free_cnt;
   assign do_start  = EN_start_writing_prt_entry && RDY_start_writing_prt_entry && !RST;
   assign do_write  = EN_write_prt_entry && RDY_write_prt_entry;
   assign do_finish = EN_finish_writing_prt_entry && RDY_finish_writing_prt_entry;
   assign do_abort  = EN_abort_writing_prt_entry && RDY_abort_writing_prt_entry;
   assign do_inv    = EN_invalidate_prt_entry && RDY_invalidate_prt_entry;
   assign do_rstart = EN_start_reading_prt_entry && RDY_start_reading_prt_entry;
   assign do_read   = EN_read_prt_entry && RDY_read_prt_entry;
   assign rd_last   = rd_null_q || rd_idx_q == len_q[rd_slot_q] - 1'b1;
   assign rd_close  = do_read && rd_last;
   // Refetch the presented beat when it is not consumed so the RAM output register holds it
   assign rd_fa     = rd_valid_q ? rd_idx_q + LEN_W'(do_read) : '0;
   assign inv_valid = do_inv && state_q[invalidate_prt_entry_slot] == VALID;
   assign inv_last  = inv_valid && ref_one;
   assign rd_ok     = state_q[start_reading_prt_entry_slot] == VALID && len_q[start_reading_prt_entry_slot] != '0 &&
                      !(inv_last && invalidate_prt_entry_slot == start_reading_prt_entry_slot);
   assign wr_addr   = AW'(wr_slot_q) * AW'(MEM_DEPTH) + AW'(wr_ptr_q);
   assign rd_addr   = AW'(rd_slot_q) * AW'(MEM_DEPTH) + AW'(rd_fa);
   assign rd_data   = rd_null_q ? '0 : ram_rdata;
   assign read_prt_entry = (RST || !rd_valid_q) ? '0 : {rd_last, rd_data};
`ifdef PRT_MULTICAST_EN
   logic [REF_WIDTH-1:0] ref_q [NUM_SLOTS], ref_d [NUM_SLOTS];
   assign ref_one = ref_q[invalidate_prt_entry_slot] <= REF_WIDTH'(1);
   always_comb begin
      ref_d = ref_q;
      if (do_start) ref_d[alloc] = start_writing_prt_entry_refs == '0 ? REF_WIDTH'(1) : start_writing_prt_entry_refs;
      if (inv_valid && !ref_one) ref_d[invalidate_prt_entry_slot] = ref_q[invalidate_prt_entry_slot] - 1'b1;
   end
   always_ff @(posedge CLK) begin
      if (RST) for (int i = 0; i < NUM_SLOTS; i++) ref_q[i] <= '0;
      else ref_q <= ref_d;
   end
`else
   assign ref_one = 1'b1;
`endif
   always_comb begin
      state_d = state_q;
      len_d = len_q;
      pend_d = pend_q;
      wr_open_d = wr_open_q;
      wr_slot_d = wr_slot_q;
      wr_ptr_d = wr_ptr_q;
      rd_open_d = rd_open_q;
      rd_slot_d = rd_slot_q;
      rd_null_d = rd_null_q;
      rd_idx_d = rd_fa;
      rd_valid_d = rd_open_q && !rd_close;
      if (do_start) begin
         state_d[alloc] = WRITING;
         wr_open_d = 1'b1;
         wr_slot_d = alloc;
         wr_ptr_d = '0;
      end
      if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_finish) begin
         state_d[wr_slot_q] = VALID;
         len_d[wr_slot_q] = wr_ptr_q;
         wr_open_d = 1'b0;
      end else if (do_abort) begin
         state_d[wr_slot_q] = FREE;
         wr_open_d = 1'b0;
      end
      if (inv_last) begin
         if (rd_open_q && rd_slot_q == invalidate_prt_entry_slot) pend_d[invalidate_prt_entry_slot] = 1'b1;
         else state_d[invalidate_prt_entry_slot] = FREE;
      end
      if (do_rstart) begin
         rd_open_d = 1'b1;
         rd_slot_d = start_reading_prt_entry_slot;
         rd_null_d = !rd_ok;
      end
      if (rd_close) begin
         rd_open_d = 1'b0;
         if (pend_d[rd_slot_q]) begin
            state_d[rd_slot_q] = FREE;
            pend_d[rd_slot_q] = 1'b0;
         end
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            state_q[i] <= FREE;
            len_q[i] <= '0;
         end
         pend_q <= '0;
         wr_open_q <= 1'b0;
         wr_slot_q <= '0;
         wr_ptr_q <= '0;
         rd_open_q <= 1'b0;
         rd_slot_q <= '0;
         rd_null_q <= 1'b0;
         rd_idx_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q <= len_d;
         pend_q <= pend_d;
         wr_open_q <= wr_open_d;
         wr_slot_q <= wr_slot_d;
         wr_ptr_q <= wr_ptr_d;
         rd_open_q <= rd_open_d;
         rd_slot_q <= rd_slot_d;
         rd_null_q <= rd_null_d;
         rd_idx_q <= rd_idx_d;
         rd_valid_q <= rd_valid_d;
      end
   end
   prt_slot_ram #(.DATA_WIDTH(DATA_WIDTH), .WORDS(NUM_SLOTS * MEM_DEPTH)) u_ram (
      .clk   (CLK),
      .we    (do_write),
      .waddr (wr_addr),
      .wdata (write_prt_entry_data),
      .raddr (rd_addr),
      .rdata (ram_rdata)
   );
endmodule

// File: tb/tb_prt_slot_table.sv
// tb_prt_slot_table: directed self-checking bench for prt_slot_table
module tb_prt_slot_table;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_sw = 1'b0, rdy_sw, en_wr = 1'b0, rdy_wr, en_fin = 1'b0, rdy_fin, en_ab = 1'b0, rdy_ab;
   logic        en_inv = 1'b0, rdy_inv, en_sr = 1'b0, rdy_sr, en_rd = 1'b0, rdy_rd, slot_free;
   logic [3:0]  sw_slot, inv_slot = '0, sr_slot = '0;
   logic [31:0] wr_data = '0;
   logic [32:0] rd_beat;
   logic [4:0]  free_cnt;
`ifdef PRT_MULTICAST_EN
   logic [2:0]  refs = 3'd1;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prt_slot_table dut (
      .CLK                          (clk),
      .RST                          (rst),
      .EN_start_writing_prt_entry   (en_sw),
      .RDY_start_writing_prt_entry  (rdy_sw),
      .start_writing_prt_entry      (sw_slot),
`ifdef PRT_MULTICAST_EN
      .start_writing_prt_entry_refs (refs),
`endif
      .EN_write_prt_entry           (en_wr),
      .RDY_write_prt_entry          (rdy_wr),
      .write_prt_entry_data         (wr_data),
      .EN_finish_writing_prt_entry  (en_fin),
      .RDY_finish_writing_prt_entry (rdy_fin),
      .EN_abort_writing_prt_entry   (en_ab),
      .RDY_abort_writing_prt_entry  (rdy_ab),
      .EN_invalidate_prt_entry      (en_inv),
      .RDY_invalidate_prt_entry     (rdy_inv),
      .invalidate_prt_entry_slot    (inv_slot),
      .EN_start_reading_prt_entry   (en_sr),
      .RDY_start_reading_prt_entry  (rdy_sr),
      .start_reading_prt_entry_slot (sr_slot),
      .EN_read_prt_entry            (en_rd),
      .RDY_read_prt_entry           (rdy_rd),
      .read_prt_entry               (rd_beat),
      .is_prt_slot_free             (slot_free),
      .free_slot_count              (free_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_frame(input int n, input logic [31:0] base, input int exp_slot);
      chk("alloc_slot", 64'(sw_slot), 64'(exp_slot));
      en_sw = 1'b1;
      tick();
      en_sw = 1'b0;
      for (int i = 0; i < n; i++) begin
         en_wr = 1'b1;
         wr_data = base + 32'(i);
         tick();
      end
      en_wr = 1'b0;
      chk("fin_rdy", 64'(rdy_fin), 64'd1);
      en_fin = 1'b1;
      tick();
      en_fin = 1'b0;
   endtask

   // called one cycle after the start_reading cycle
   task automatic read_rest(input int n, input logic [31:0] base);
      chk("rd_latency", 64'(rdy_rd), 64'd0);
      tick();
      for (int k = 0; k < n; k++) begin
         chk("rd_rdy", 64'(rdy_rd), 64'd1);
         chk("rd_beat", 64'(rd_beat), 64'({k == n - 1, base + 32'(k)}));
         en_rd = 1'b1;
         tick();
      end
      en_rd = 1'b0;
      chk("rd_done", 64'(rdy_rd), 64'd0);
   endtask

   task automatic read_frame(input int slot, input int n, input logic [31:0] base);
      en_sr = 1'b1;
      sr_slot = 4'(slot);
      tick();
      en_sr = 1'b0;
      read_rest(n, base);
   endtask

   task automatic invalidate(input int slot);
      en_inv = 1'b1;
      inv_slot = 4'(slot);
      tick();
      en_inv = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_rdy_sw", 64'(rdy_sw), 64'd1);
      chk("rst_rdy_wr", 64'(rdy_wr), 64'd0);
      chk("rst_rdy_inv", 64'(rdy_inv), 64'd0);
      chk("rst_rdy_sr", 64'(rdy_sr), 64'd0);
      chk("rst_rdy_rd", 64'(rdy_rd), 64'd0);
      chk("rst_beat", 64'(rd_beat), 64'd0);
      chk("rst_count", 64'(free_cnt), 64'd16);
      rst = 1'b0;
      tick();
      chk("idle_free", 64'(slot_free), 64'd1);
      chk("idle_count", 64'(free_cnt), 64'd16);
      chk("idle_rdy_inv", 64'(rdy_inv), 64'd1);
      chk("idle_rdy_sr", 64'(rdy_sr), 64'd1);
      // basic write/read
      write_frame(5, 32'd0, 0);
      chk("basic_count", 64'(free_cnt), 64'd15);
      read_frame(0, 5, 32'd0);
      // fill all slots
      for (int s = 1; s < 16; s++) write_frame(4, 32'(s * 16), s);
      chk("full_free", 64'(slot_free), 64'd0);
      chk("full_count", 64'(free_cnt), 64'd0);
      chk("full_rdy_sw", 64'(rdy_sw), 64'd0);
      invalidate(7);
      chk("reuse_count", 64'(free_cnt), 64'd1);
      chk("reuse_free", 64'(slot_free), 64'd1);
      write_frame(2, 32'h70, 7);
      chk("refill_count", 64'(free_cnt), 64'd0);
      // deferred free of slot 2 under read
      en_sr = 1'b1;
      sr_slot = 4'd2;
      tick();
      en_sr = 1'b0;
      tick();
      chk("df_b0", 64'(rd_beat), 64'h0_0000_0020);
      en_rd = 1'b1;
      tick();
      chk("df_b1", 64'(rd_beat), 64'h0_0000_0021);
      en_inv = 1'b1;
      inv_slot = 4'd2;
      tick();
      en_inv = 1'b0;
      chk("df_b2", 64'(rd_beat), 64'h0_0000_0022);
      chk("df_pend_count", 64'(free_cnt), 64'd0);
      tick();
      chk("df_b3", 64'(rd_beat), 64'h1_0000_0023);
      chk("df_pend_rdy_sw", 64'(rdy_sw), 64'd0);
      tick();
      en_rd = 1'b0;
      chk("df_freed_count", 64'(free_cnt), 64'd1);
      chk("df_freed_slot", 64'(sw_slot), 64'd2);
      chk("df_rd_done", 64'(rdy_rd), 64'd0);
      for (int s = 0; s < 16; s++) invalidate(s);
      chk("all_freed", 64'(free_cnt), 64'd16);
      // abort
      chk("ab_slot", 64'(sw_slot), 64'd0);
      en_sw = 1'b1;
      tick();
      en_sw = 1'b0;
      chk("ab_rdy_sw", 64'(rdy_sw), 64'd0);
      for (int i = 0; i < 3; i++) begin
         en_wr = 1'b1;
         wr_data = 32'hEE + 32'(i);
         tick();
      end
      en_wr = 1'b0;
      chk("ab_mid_count", 64'(free_cnt), 64'd15);
      chk("ab_rdy", 64'(rdy_ab), 64'd1);
      en_ab = 1'b1;
      tick();
      en_ab = 1'b0;
      chk("ab_count", 64'(free_cnt), 64'd16);
      chk("ab_rdy_fin", 64'(rdy_fin), 64'd0);
      read_frame(0, 1, 32'd0);
      // invalidate and start_reading on the same slot in one cycle
      write_frame(2, 32'hB0, 0);
      en_inv = 1'b1;
      inv_slot = 4'd0;
      en_sr = 1'b1;
      sr_slot = 4'd0;
      tick();
      en_inv = 1'b0;
      en_sr = 1'b0;
      read_rest(1, 32'd0);
      chk("invrd_count", 64'(free_cnt), 64'd16);
      // finish and start_reading on the slot being finished
      en_sw = 1'b1;
      tick();
      en_sw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         en_wr = 1'b1;
         wr_data = 32'hA0 + 32'(i);
         tick();
      end
      en_wr = 1'b0;
      en_fin = 1'b1;
      en_sr = 1'b1;
      sr_slot = 4'd0;
      tick();
      en_fin = 1'b0;
      en_sr = 1'b0;
      read_rest(1, 32'd0);
      read_frame(0, 3, 32'hA0);
      // zero-beat frame
      write_frame(0, 32'd0, 1);
      chk("zero_count", 64'(free_cnt), 64'd14);
      read_frame(1, 1, 32'd0);
      invalidate(1);
      chk("zero_freed", 64'(free_cnt), 64'd15);
      // full-depth write to slot 1 concurrent with reading slot 0
      chk("cc_slot", 64'(sw_slot), 64'd1);
      en_sw = 1'b1;
      en_sr = 1'b1;
      sr_slot = 4'd0;
      tick();
      en_sw = 1'b0;
      en_sr = 1'b0;
      for (int t = 0; t < 512; t++) begin
         chk("cc_rdy_wr", 64'(rdy_wr), 64'd1);
         en_wr = 1'b1;
         wr_data = 32'h1000 + 32'(t);
         en_rd = 1'b0;
         if (t >= 1 && t <= 3) begin
            chk("cc_beat", 64'(rd_beat), 64'({t == 3, 32'hA0 + 32'(t - 1)}));
            en_rd = 1'b1;
         end
         if (t == 4) chk("cc_rd_done", 64'(rdy_rd), 64'd0);
         tick();
      end
      en_wr = 1'b0;
      en_rd = 1'b0;
      chk("ovf_rdy_wr", 64'(rdy_wr), 64'd0);
      chk("ovf_rdy_fin", 64'(rdy_fin), 64'd1);
      en_fin = 1'b1;
      tick();
      en_fin = 1'b0;
      chk("ovf_count", 64'(free_cnt), 64'd14);
      read_frame(1, 512, 32'h1000);
      read_frame(0, 3, 32'hA0);
`ifdef PRT_MULTICAST_EN
      refs = 3'd3;
      write_frame(1, 32'hC0, 2);
      chk("mc_count", 64'(free_cnt), 64'd13);
      invalidate(2);
      invalidate(2);
      chk("mc_held", 64'(free_cnt), 64'd13);
      read_frame(2, 1, 32'hC0);
      invalidate(2);
      chk("mc_freed", 64'(free_cnt), 64'd14);
      refs = 3'd0;
      write_frame(1, 32'hC8, 2);
      invalidate(2);
      chk("mc_zero_freed", 64'(free_cnt), 64'd14);
`else
      write_frame(1, 32'hC0, 2);
      chk("uc_count", 64'(free_cnt), 64'd13);
      invalidate(2);
      chk("uc_freed", 64'(free_cnt), 64'd14);
`endif
      // reset in the middle of both sessions
      en_sw = 1'b1;
      tick();
      en_sw = 1'b0;
      en_wr = 1'b1;
      wr_data = 32'h77;
      en_sr = 1'b1;
      sr_slot = 4'd0;
      tick();
      en_wr = 1'b0;
      en_sr = 1'b0;
      rst = 1'b1;
      tick();
      chk("mrst_rdy_rd", 64'(rdy_rd), 64'd0);
      chk("mrst_beat", 64'(rd_beat), 64'd0);
      chk("mrst_rdy_wr", 64'(rdy_wr), 64'd0);
      chk("mrst_rdy_fin", 64'(rdy_fin), 64'd0);
      chk("mrst_count", 64'(free_cnt), 64'd16);
      chk("mrst_rdy_sw", 64'(rdy_sw), 64'd1);
      rst = 1'b0;
      tick();
      chk("mrst_rdy_sr", 64'(rdy_sr), 64'd1);
      read_frame(0, 1, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
